shutter_ctrl_seq: RTL and testbench
===================================

Name: shutter_ctrl_seq

Overview:
Shutter command sequencer for the quabo mechanical shutter.
- Accepts open/close requests from the slow-control side.
- Drives the level-mode shutter_command line.
- Synchronises and debounces the shutter_status and light_sensor_status inputs.
- Confirms each move against debounced status, with a timeout.
- Sits upstream of the step-drive/shutter pin selector. `en` is asserted only when the board position selects shutter mode (pos = 2'b01).

Parameters:
DEBOUNCE_CYC, 1000, consecutive stable cycles before a debounced input changes value (≥2).
TIMEOUT_CYC, 25000000, max cycles in WAIT before a timeout is declared (≥2).
CNT_W, 32, timer/debounce counter width; must hold TIMEOUT_CYC and DEBOUNCE_CYC.

Ports:
clk  in  1  system clock; only clock.
rst_n  in  1  asynchronous active-low reset.
en  in  1  block enable (shutter mode selected on shared pins).
req_valid  in  1  request strobe.
req_open  in  1  requested target: 1 = open, 0 = close.
req_ready  out  1  request accepted when req_valid & req_ready.
shutter_command  out  1  registered level to shutter driver: 1 = open.
shutter_status  in  1  raw asynchronous shutter position input: 1 = open.
light_sensor_status  in  1  raw asynchronous light-sensor input.
status_open  out  1  debounced shutter_status.
light_detected  out  1  debounced light_sensor_status.
busy  out  1  high while in WAIT.
done  out  1  one-cycle pulse when a move completes (success or timeout).
err_timeout  out  1  sticky timeout flag.
err_clr  in  1  clears err_timeout.

Behaviour:
- Reset values: shutter_command=0, status_open=0, light_detected=0, busy=0, done=0, err_timeout=0, req_ready=0, state=IDLE, counters=0. The synchroniser flops also reset to 0.
- Input path, per status input:
  - Two-flop synchroniser, then debouncer.
  - Debouncer counter clears whenever the synced value equals the debounced value or changes.
  - Debounced output takes the synced value after DEBOUNCE_CYC consecutive cycles of a differing, stable synced value.
  - Input-to-output latency: 2 + DEBOUNCE_CYC cycles.
  - Glitches shorter than DEBOUNCE_CYC never propagate.
- req_ready = (state==IDLE) & en, combinational from registered state.
- FSM states: IDLE, WAIT, FINISH.
  - IDLE: on req_valid & req_ready at edge N:
    - latch target = req_open;
    - shutter_command = req_open, visible at N+1;
    - timer = 0; go to WAIT.
  - WAIT (busy=1), evaluated in this order:
    - if en=0: abort to IDLE. No done pulse, err unchanged, shutter_command holds its value.
    - else if status_open==target: go to FINISH.
    - else if timer==TIMEOUT_CYC-1: set err_timeout, go to FINISH.
    - else timer += 1.
  - FINISH: done=1 for exactly one cycle, then IDLE.
- Latency: if status already equals target at accept, done is asserted in cycle N+2. Minimum request-to-request spacing is 3 cycles.
- Timeout: err_timeout sets on the cycle WAIT has spent TIMEOUT_CYC cycles. shutter_command is NOT reverted; the shutter remains commanded to target.
- err_clr coinciding with a timeout-set cycle: set wins.
- Requests while not ready are ignored; there is no queueing.
- en low in IDLE: req_ready=0. Debouncers keep running regardless of en.
- Counters saturate and never wrap. The timer stops at TIMEOUT_CYC-1 by construction.
- rst_n asserted mid-move: immediate return to reset values, including shutter_command=0 (closed).

Decomposition:
- Package shutter_pkg: state enum (IDLE, WAIT, FINISH), constants SHUTTER_OPEN=1'b1 and SHUTTER_CLOSE=1'b0, and the CNT_W default.
- Sub-module sync_debounce (params DEBOUNCE_CYC, CNT_W; ports clk, rst_n, din, dout), instantiated twice: once for shutter_status, once for light_sensor_status.

Test Plan (DEBOUNCE_CYC=4, TIMEOUT_CYC=100):
- Reset, en=1, req_open=1 pulse at cycle 10; shutter_status rises at cycle 20:
  - shutter_command=1 at cycle 11;
  - status_open=1 at cycle 26;
  - done pulse at cycle 27;
  - err_timeout=0.
- Request open while status_open already 1: done exactly 2 cycles after accept; busy high for 1 cycle.
- Request close, shutter_status held 1:
  - err_timeout=1 and done pulse at accept+101;
  - shutter_command stays 0;
  - err_clr later clears the flag;
  - err_clr asserted on the set cycle leaves the flag at 1.
- Apply 3-cycle glitches on light_sensor_status → light_detected stays 0. A 6-cycle high → light_detected=1 six cycles after the rise.
- Drop en in WAIT → back to IDLE next cycle, no done pulse, req_ready=0 until en returns; req_valid during busy is ignored.
- Assert rst_n=0 mid-WAIT with shutter_command=1 → all outputs 0 immediately (asynchronously), state IDLE after release.

Source files
------------

// File: rtl/shutter_pkg.sv
// Shared types and constants for the quabo shutter command sequencer.
package shutter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam logic SHUTTER_OPEN  = 1'b1;
  localparam logic SHUTTER_CLOSE = 1'b0;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debouncer for one asynchronous status input.
module sync_debounce #(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             s1_q;
  logic             s2_q;
  logic             dout_q;
  logic             dout_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      dout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  // A binary input can only "change" back to the debounced value, so clearing
  // on equality also covers clearing on a change; cnt never exceeds CNT_LAST.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = '0;
    if (s2_q != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/shutter_ctrl_seq.sv
// Shutter command sequencer: accepts open/close requests, drives the level
// command line and confirms each move against debounced status with a timeout.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_valid may be raised or dropped at any time and
// a request seen while req_ready is low is dropped, never queued.
module shutter_ctrl_seq
  import shutter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int TIMEOUT_CYC  = 25000000,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req_valid,
  input  logic       req_open,
  output logic       req_ready,
  output logic       shutter_command,
  input  logic       shutter_status,
  input  logic       light_sensor_status,
  output logic       status_open,
  output logic       light_detected,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  input  logic       err_clr,
  output logic [1:0] dbg_state
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q;
  state_e           state_d;
  logic             cmd_q;
  logic             cmd_d;
  logic             target_q;
  logic             target_d;
  logic             err_q;
  logic             err_d;
  logic             set_err;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;

  sync_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_db_status (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (shutter_status),
    .dout  (status_open)
  );

  sync_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_db_light (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (light_sensor_status),
    .dout  (light_detected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= SHUTTER_CLOSE;
      target_q <= SHUTTER_CLOSE;
      err_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      target_q <= target_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
    end
  end

  assign req_ready = (state_q == IDLE) & en;

  // Losing en mid-move abandons confirmation but leaves the command line as is.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    target_d = target_q;
    timer_d  = timer_q;
    set_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          target_d = req_open;
          cmd_d    = req_open;
          timer_d  = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (status_open == target_q) begin
          state_d = FINISH;
        end else if (timer_q == TIMER_LAST) begin
          set_err = 1'b1;
          state_d = FINISH;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A timeout on the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (set_err) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  assign shutter_command = cmd_q;
  assign busy            = (state_q == WAIT);
  assign done            = (state_q == FINISH);
  assign err_timeout     = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_shutter_ctrl_seq.sv
// Bench for shutter_ctrl_seq: directed scenarios plus random traffic, all
// outputs scored every cycle against a behavioural model.
module tb_shutter_ctrl_seq;

  localparam int DEB = 4;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_open = 1'b0;
  logic       shutter_status = 1'b0;
  logic       light_sensor_status = 1'b0;
  logic       err_clr = 1'b0;
  logic       req_ready;
  logic       shutter_command;
  logic       status_open;
  logic       light_detected;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  logic [6:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  shutter_ctrl_seq #(
    .DEBOUNCE_CYC (DEB),
    .TIMEOUT_CYC  (TO),
    .CNT_W        (32)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .req_valid           (req_valid),
    .req_open            (req_open),
    .req_ready           (req_ready),
    .shutter_command     (shutter_command),
    .shutter_status      (shutter_status),
    .light_sensor_status (light_sensor_status),
    .status_open         (status_open),
    .light_detected      (light_detected),
    .busy                (busy),
    .done                (done),
    .err_timeout         (err_timeout),
    .err_clr             (err_clr),
    .dbg_state           (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_cmd, m_err, m_busy, m_fin, m_tgt, m_sopen, m_light;
  int m_edge, m_acc_edge;
  bit hs[$];
  bit hl[$];

  // The debounced value flips once the last DEB synchronised samples
  // (raw samples two edges old and earlier) all disagree with it.
  function automatic bit deb_next(input bit q[$], input bit cur);
    for (int i = 1; i <= DEB; i++) begin
      if (q[q.size() - 1 - i] == cur) return cur;
    end
    return !cur;
  endfunction

  function automatic logic [6:0] exp_vec();
    return {(!m_busy && !m_fin && en), m_cmd, m_sopen, m_light, m_busy, m_fin, m_err};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit set_err;
    bit ns;
    bit nl;
    if (!rst_n) begin
      m_cmd = 0; m_err = 0; m_busy = 0; m_fin = 0; m_tgt = 0;
      m_sopen = 0; m_light = 0; m_edge = 0; m_acc_edge = 0;
      hs.delete();
      hl.delete();
      repeat (DEB + 2) begin
        hs.push_back(1'b0);
        hl.push_back(1'b0);
      end
      exp_q.delete();
      exp_q.push_back(exp_vec());
    end else begin
      set_err = 0;
      m_edge++;
      if (m_fin) begin
        m_fin = 0;
      end else if (m_busy) begin
        if (!en) begin
          m_busy = 0;
        end else if (m_sopen == m_tgt) begin
          m_busy = 0;
          m_fin  = 1;
        end else if (m_edge - m_acc_edge == TO) begin
          m_busy  = 0;
          m_fin   = 1;
          set_err = 1;
        end
      end else if (req_valid && en) begin
        m_tgt      = req_open;
        m_cmd      = req_open;
        m_busy     = 1;
        m_acc_edge = m_edge;
      end
      if (set_err) m_err = 1;
      else if (err_clr) m_err = 0;
      ns = deb_next(hs, m_sopen);
      nl = deb_next(hl, m_light);
      m_sopen = ns;
      m_light = nl;
      hs.push_back(shutter_status);
      hl.push_back(light_sensor_status);
      while (hs.size() > 16) void'(hs.pop_front());
      while (hl.size() > 16) void'(hl.pop_front());
      exp_q.push_back(exp_vec());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [6:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard @%0t: got empty expected queue, expected one entry", $time);
    end else begin
      e = exp_q.pop_front();
      check("req_ready",       req_ready,       e[6]);
      check("shutter_command", shutter_command, e[5]);
      check("status_open",     status_open,     e[4]);
      check("light_detected",  light_detected,  e[3]);
      check("busy",            busy,            e[2]);
      check("done",            done,            e[1]);
      check("err_timeout",     err_timeout,     e[0]);
    end
  endtask

  task automatic request(input logic open);
    req_valid = 1'b1;
    req_open  = open;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int k);
    k = 0;
    do begin
      cycle();
      k++;
    end while (!done && k < limit);
    if (!done) check("done_wait", done, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    repeat (3) cycle();
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (5) cycle();

    // open move confirmed by a later status rise
    request(1'b1);
    check("cmd_after_accept", shutter_command, 1);
    repeat (8) cycle();
    shutter_status = 1'b1;
    wait_done(40, k);
    check("open_done_lat", k, 7);
    check("open_no_err", err_timeout, 0);
    cycle();

    // already open: done two cycles after accept
    request(1'b1);
    check("busy_short", busy, 1);
    cycle();
    check("already_done", done, 1);
    cycle();

    // close with status stuck open: timeout, err_clr on the set cycle loses
    request(1'b0);
    repeat (TO - 1) cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("to_done", done, 1);
    check("to_err_set_wins", err_timeout, 1);
    check("to_cmd_held", shutter_command, 0);
    cycle();
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("err_cleared", err_timeout, 0);

    // light-sensor glitches, then a real 6-cycle pulse
    repeat (2) begin
      light_sensor_status = 1'b1;
      repeat (3) cycle();
      light_sensor_status = 1'b0;
      repeat (5) cycle();
    end
    check("glitch_blocked", light_detected, 0);
    light_sensor_status = 1'b1;
    repeat (5) cycle();
    check("light_before", light_detected, 0);
    cycle();
    check("light_after", light_detected, 1);
    light_sensor_status = 1'b0;
    repeat (8) cycle();

    // en dropped mid-wait; requests during busy ignored
    request(1'b0);
    req_valid = 1'b1;
    req_open  = 1'b1;
    repeat (2) cycle();
    req_valid = 1'b0;
    en = 1'b0;
    cycle();
    check("abort_busy", busy, 0);
    check("abort_no_done", done, 0);
    check("abort_not_ready", req_ready, 0);
    check("abort_cmd_held", shutter_command, 0);
    repeat (3) cycle();
    en = 1'b1;
    cycle();

    // asynchronous reset in the middle of an open move
    shutter_status = 1'b0;
    repeat (8) cycle();
    request(1'b1);
    repeat (3) cycle();
    check("pre_rst_cmd", shutter_command, 1);
    @(posedge clk);
    #2;
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_cmd",   shutter_command, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_err",   err_timeout, 0);
    check("rst_ready", req_ready, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    en    = 1'b1;
    cycle();
    check("post_rst_ready", req_ready, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      en        = ($urandom_range(0, 29) != 0);
      req_valid = ($urandom_range(0, 3) == 0);
      req_open  = $urandom_range(0, 1);
      err_clr   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0) shutter_status = ~shutter_status;
      if ($urandom_range(0, 5) == 0) light_sensor_status = ~light_sensor_status;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
